image_rom_arbiter: RTL and testbench
====================================

Name: image_rom_arbiter

Overview:
- Shares one read port of the dual-port `image_rom` (24-bit RGB pixels, 17-bit word address) between NUM_REQ pixel consumers, e.g. the VGA scan-out engine and the image-processing core.
- Grants one read per cycle using round-robin arbitration.
- Tracks every in-flight read through the ROM's fixed read latency, and returns each pixel to the requester that issued it.
- Sits between the consumers and one ROM port; the ROM's `aclr` is tied low and `rden` is driven by this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 17, ROM word address width.
- DATA_W, 24, pixel width (8:8:8 RGB).
- DEPTH, 76800, valid pixel count (320x240); addresses >= DEPTH are out of range.
- RD_LATENCY, 2, clock edges from address sample to valid `rom_q` (registered address plus registered output).

Ports:
- clk  in  1  single clock, shared with the ROM port clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot grant (combinational); the request is accepted at the clock edge where valid & ready.
- rsp_valid  out  NUM_REQ  one-hot response strobe, single cycle.
- rsp_data  out  DATA_W  pixel for the requester flagged in rsp_valid.
- rsp_err  out  1  high with rsp_valid when the accepted address was >= DEPTH.
- rom_rden  out  1  ROM read enable.
- rom_address  out  ADDR_W  ROM address.
- rom_q  in  DATA_W  ROM read data.

Behaviour:
- Reset state: all outputs 0. rr_ptr = 0. Tag pipeline cleared.
- Reset asserted mid-operation discards all in-flight reads; no rsp_valid is ever issued for them.

Arbitration:
- Combinational. Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ. The first one with req_valid gets req_ready.
- At most one req_ready per cycle. req_ready = 0 when no req_valid is set.
- On acceptance, rr_ptr <= granted index + 1 (mod NUM_REQ). Otherwise rr_ptr holds.
- A requester that keeps req_valid high waits at most NUM_REQ-1 cycles.
- Requesters hold req_addr stable while req_valid && !req_ready. A requester may deassert valid before a grant; this is legal and nothing is issued.

ROM drive:
- rom_address = granted req_addr, combinational.
- rom_rden = 1 only when a grant occurs and the address is < DEPTH.
- When no grant occurs, rom_address holds its last granted value (a register shadows the mux output) to avoid needless toggling.
- An out-of-range grant is still accepted. It keeps rom_rden = 0 and carries err = 1 through the pipeline.

Tag pipeline:
- RD_LATENCY stages of {valid, id[$clog2(NUM_REQ)], err}.
- Stage 0 is loaded at the accept edge. Each stage shifts every cycle; there is no stall and consumers cannot back-pressure.
- Tail stage valid drives rsp_valid[id] high for exactly one cycle, starting RD_LATENCY edges after the accept edge.
- rsp_data = rom_q when err = 0, 24'h0 when err = 1. rsp_err = tail err.
- rsp_data = 0 whenever rsp_valid = 0.

Throughput and ordering:
- Full throughput is one accept per cycle, so up to RD_LATENCY reads are in flight.
- Responses return in accept order, so each requester sees its responses in request order.

Boundary conditions:
- NUM_REQ = 1 degenerates to a pass-through with tagging; rr_ptr stays 0.
- Address DEPTH-1 is valid. Address DEPTH is an error.
- Address 2^ADDR_W-1 is an error.

Decomposition:
- Package `image_rom_pkg` holds:
  - IMG_W = 320, IMG_H = 240, DEPTH = IMG_W*IMG_H.
  - ADDR_W, DATA_W, RD_LATENCY.
  - typedef pixel_t (logic [23:0]).
  - typedef rom_addr_t.
  - typedef struct tag_t {valid, id, err}.
- One sub-module: `rr_arbiter` (NUM_REQ requests, rr_ptr state, one-hot grant, advance-on-accept input), reusable elsewhere.
- Tag pipeline, ROM drive and response mux live in the top.

Test Plan:
- Single requester: req0 reads addr 0 then addr 1 on consecutive cycles. Expect req_ready[0] both cycles, rsp_valid[0] 2 cycles after each accept, rsp_data = ROM init words 0 and 1, rsp_err = 0.
- Contention: req0 and req1 both hold valid for 6 cycles with fixed addrs 5 and 9. Expect grants alternating 0,1,0,1,0,1 from reset and responses alternating rom[5], rom[9] with matching rsp_valid bits.
- Out of range: req1 addr 76800. Expect accept with rom_rden = 0, and after 2 edges rsp_valid[1] = 1, rsp_err = 1, rsp_data = 0. Addr 76799 returns rom[76799], err = 0.
- Reset mid-flight: accept 2 reads, assert rst_n = 0 the next cycle for 1 cycle. Expect no rsp_valid afterwards, all outputs 0 during reset, and the first grant after release going to req0.
- Idle and hold: no req_valid for 10 cycles. Expect rom_rden = 0, rom_address stable at its last value, rr_ptr unchanged.
- Fairness soak: random valid/address on 2 requesters for 2000 cycles against a reference model. Expect every accepted request answered exactly once, in order, with correct data, and no requester waiting more than 1 cycle while continuously valid.

Source files
------------

// File: rtl/image_rom_pkg.sv
// Shared constants and types for the image ROM and its read-port arbiter.
package image_rom_pkg;

  localparam int unsigned IMG_W      = 320;
  localparam int unsigned IMG_H      = 240;
  localparam int unsigned DEPTH      = IMG_W * IMG_H;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned RD_LATENCY = 2;
  // Wide enough for the largest supported requester count (4).
  localparam int unsigned ID_W       = 2;

  typedef logic [23:0]       pixel_t;
  typedef logic [ADDR_W-1:0] rom_addr_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the
// granted index only on accept.
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              accept_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] hi_idx, lo_idx;
  logic            hi_found, any_req;

  // Lowest requester at/after the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    any_req  = |req_i;
    for (int j = NumReq - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        lo_idx = IdxW'(j);
        if (j >= int'(ptr_q)) begin
          hi_idx   = IdxW'(j);
          hi_found = 1'b1;
        end
      end
    end
    idx_o = hi_found ? hi_idx : lo_idx;
    gnt_o = '0;
    for (int j = 0; j < NumReq; j++) begin
      gnt_o[j] = any_req && (int'(idx_o) == j);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = (int'(idx_o) == int'(NumReq) - 1) ? '0 : idx_o + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/image_rom_arbiter.sv
// Shares one image ROM read port among NUM_REQ consumers; tags each read through
// the fixed ROM latency and routes the pixel back to its issuer.
module image_rom_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_W     = image_rom_pkg::ADDR_W,
  parameter int unsigned DATA_W     = image_rom_pkg::DATA_W,
  parameter int unsigned DEPTH      = image_rom_pkg::DEPTH,
  parameter int unsigned RD_LATENCY = image_rom_pkg::RD_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      rom_rden,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q
);

  import image_rom_pkg::*;

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req_gated;
  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     gnt_idx;
  logic               accept;
  logic               gnt_err;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  tag_t               tag_in;
  tag_t               tail;
  tag_t               pipe_q [RD_LATENCY];

  // Gating with reset keeps every output low while reset is held.
  assign req_gated = req_valid & {NUM_REQ{rst_n}};
  assign accept    = |gnt;
  assign req_ready = gnt;

  rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_arb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req_gated),
    .accept_i (accept),
    .gnt_o    (gnt),
    .idx_o    (gnt_idx)
  );

  always_comb begin
    gnt_addr    = req_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
    gnt_err     = 32'(gnt_addr) >= DEPTH;
    // Hold the last granted address when idle to avoid toggling the ROM bus.
    rom_address = accept ? gnt_addr : addr_q;
    rom_rden    = accept && !gnt_err;
    addr_d      = rom_address;
    tag_in      = '0;
    tag_in.valid = accept;
    tag_in.id    = ID_W'(gnt_idx);
    tag_in.err   = accept && gnt_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      addr_q    <= addr_d;
      pipe_q[0] <= tag_in;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail = pipe_q[RD_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_valid[i] = tail.valid && (tail.id == ID_W'(i));
    end
    rsp_err  = tail.valid && tail.err;
    rsp_data = (tail.valid && !tail.err) ? rom_q : '0;
  end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed vector table, reset corner cases and a randomized soak against a
// reference arbiter and ROM model.
module tb_image_rom_arbiter;

  localparam int unsigned DEPTH = 76800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [33:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [23:0] rsp_data;
  logic        rsp_err;
  logic        rom_rden;
  logic [16:0] rom_address;
  logic [23:0] rom_q;
  logic [16:0] rom_a_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  image_rom_arbiter #(
    .NUM_REQ    (2),
    .ADDR_W     (17),
    .DATA_W     (24),
    .DEPTH      (DEPTH),
    .RD_LATENCY (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .rom_rden    (rom_rden),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  function automatic logic [23:0] rom_f(input logic [16:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C, 7'h55, a[16]};
  endfunction

  // Registered address + registered output ROM model.
  always_ff @(posedge clk) begin
    if (rom_rden) rom_a_q <= rom_address;
    rom_q <= rom_f(rom_a_q);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  v;
    logic [16:0] a0, a1;
    logic [1:0]  rdy;
    logic        rden;
    logic [16:0] addr;
    logic [1:0]  rv;
    logic        rerr;
    logic [16:0] raddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic [1:0] v, logic [16:0] a0, logic [16:0] a1,
                              logic [1:0] rdy, logic rden, logic [16:0] addr,
                              logic [1:0] rv, logic rerr, logic [16:0] raddr);
    vec_t r;
    r.rst = rst; r.v = v; r.a0 = a0; r.a1 = a1; r.rdy = rdy; r.rden = rden;
    r.addr = addr; r.rv = rv; r.rerr = rerr; r.raddr = raddr;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ready"}, 32'(req_ready), 0);
    check({tag, " rden"}, 32'(rom_rden), 0);
    check({tag, " addr"}, 32'(rom_address), 0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, " rsp_err"}, 32'(rsp_err), 0);
    check({tag, " rsp_data"}, 32'(rsp_data), 0);
  endtask

  // Soak model state.
  int          m_ptr;
  logic        h0_v, h1_v, h0_err, h1_err;
  logic        h0_id, h1_id;
  logic [16:0] h0_addr, h1_addr;
  int          wait_cnt [2];
  logic [1:0]  sv;
  logic [16:0] sa [2];
  logic [1:0]  hold;

  initial begin
    logic [23:0] exp_data;
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_addr = {17'd7, 17'd6};
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;

    // Single requester, then contention, out-of-range, idle hold and pointer retention.
    vecs.push_back(mk(1, 2'b01, 0, 0, 2'b01, 1, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b01, 1, 0, 2'b01, 1, 1, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 1, 2'b01, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 1, 2'b01, 0, 1));
    vecs.push_back(mk(1, 2'b11, 5, 9, 2'b01, 1, 5, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 5, 9, 2'b10, 1, 9, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 5, 9, 2'b01, 1, 5, 2'b01, 0, 5));
    vecs.push_back(mk(0, 2'b11, 5, 9, 2'b10, 1, 9, 2'b10, 0, 9));
    vecs.push_back(mk(0, 2'b11, 5, 9, 2'b01, 1, 5, 2'b01, 0, 5));
    vecs.push_back(mk(0, 2'b11, 5, 9, 2'b10, 1, 9, 2'b10, 0, 9));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 9, 2'b01, 0, 5));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 9, 2'b10, 0, 9));
    vecs.push_back(mk(0, 2'b10, 0, 76800, 2'b10, 0, 76800, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 76799, 2'b10, 1, 76799, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 76799, 2'b10, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 76799, 2'b10, 0, 76799));
    vecs.push_back(mk(0, 2'b01, 17'h1FFFF, 0, 2'b01, 0, 17'h1FFFF, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 17'h1FFFF, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 17'h1FFFF, 2'b01, 1, 0));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 17'h1FFFF, 2'b00, 0, 0));
    end
    vecs.push_back(mk(0, 2'b11, 3, 4, 2'b10, 1, 4, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 3, 4, 2'b01, 1, 3, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 3, 2'b10, 0, 4));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 3, 2'b01, 0, 3));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      req_valid = vecs[i].v;
      req_addr  = {vecs[i].a1, vecs[i].a0};
      #1;
      exp_data = (vecs[i].rv == 2'b00 || vecs[i].rerr) ? 24'h0 : rom_f(vecs[i].raddr);
      check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].rdy));
      check($sformatf("vec%0d rden", i), 32'(rom_rden), 32'(vecs[i].rden));
      check($sformatf("vec%0d addr", i), 32'(rom_address), 32'(vecs[i].addr));
      check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rv));
      check($sformatf("vec%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].rerr));
      check($sformatf("vec%0d rsp_data", i), 32'(rsp_data), 32'(exp_data));
    end

    // Reset while two reads are in flight: nothing may emerge afterwards.
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_addr  = {17'd11, 17'd10};
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("post-reset rsp_valid %0d", i), 32'(rsp_valid), 0);
      @(negedge clk);
    end
    req_valid = 2'b11;
    #1;
    check("post-reset first grant", 32'(req_ready), 32'(2'b01));

    // Randomized soak against reference arbiter and latency model.
    do_reset();
    m_ptr = 0;
    h0_v = 0; h1_v = 0; h0_err = 0; h1_err = 0; h0_id = 0; h1_id = 0;
    h0_addr = 0; h1_addr = 0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;
    hold = 2'b00;
    sv = 2'b00;
    sa[0] = 0; sa[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      logic [1:0] exp_rdy;
      logic       acc, g, aerr;
      int         r;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          sv[i] = 1'($urandom_range(0, 1));
          r = int'($urandom_range(0, 9));
          if (r == 0)      sa[i] = 17'(DEPTH - 1);
          else if (r == 1) sa[i] = 17'(DEPTH);
          else if (r == 2) sa[i] = 17'($urandom);
          else             sa[i] = 17'($urandom_range(0, DEPTH - 1));
        end
      end
      req_valid = sv;
      req_addr  = {sa[1], sa[0]};
      #1;
      acc = 1'b0;
      g   = 1'b0;
      if (sv[m_ptr]) begin
        acc = 1'b1; g = 1'(m_ptr);
      end else if (sv[1 - m_ptr]) begin
        acc = 1'b1; g = 1'(1 - m_ptr);
      end
      exp_rdy = acc ? (2'b01 << g) : 2'b00;
      aerr = acc && (32'(sa[g]) >= DEPTH);
      check($sformatf("soak%0d ready", c), 32'(req_ready), 32'(exp_rdy));
      check($sformatf("soak%0d rden", c), 32'(rom_rden), 32'(acc && !aerr));
      check($sformatf("soak%0d rsp_valid", c), 32'(rsp_valid),
            32'(h1_v ? (2'b01 << h1_id) : 2'b00));
      check($sformatf("soak%0d rsp_err", c), 32'(rsp_err), 32'(h1_v && h1_err));
      check($sformatf("soak%0d rsp_data", c), 32'(rsp_data),
            32'((h1_v && !h1_err) ? rom_f(h1_addr) : 24'h0));
      for (int i = 0; i < 2; i++) begin
        wait_cnt[i] = (sv[i] && !exp_rdy[i]) ? wait_cnt[i] + 1 : 0;
        hold[i] = sv[i] && !exp_rdy[i];
      end
      check($sformatf("soak%0d wait", c), 32'(wait_cnt[0] > 1 || wait_cnt[1] > 1), 0);
      h1_v = h0_v; h1_id = h0_id; h1_err = h0_err; h1_addr = h0_addr;
      h0_v = acc; h0_id = g; h0_err = aerr; h0_addr = sa[g];
      if (acc) m_ptr = (int'(g) + 1) % 2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
